// File: rtl/pmem_responder.sv
// pmem_responder -- memory side of the cacheline pmem interface.
//
// Serves whole-line reads and writes from an internal line array. Each
// accepted request completes with a one-cycle pmem_resp pulse a fixed
// number of cycles after acceptance.
//
// Parameters:
//   LINE_W      line width in bits
//   ADDR_W      pmem_address width
//   DEPTH_LOG2  log2 of the number of stored lines
//   LATENCY     edges from acceptance to entering RESP (1..255)
//   INIT_ZERO   1: reset clears the array, 0: array keeps its contents
//
// Build option:
//   PMEM_RESP_JITTER_EN  when defined, a 16-bit LFSR adds 0..7 extra
//                        cycles of latency per transaction.
//
// Ports:
//   clk           clock, all state on the rising edge
//   rst           asynchronous active-low reset
//   pmem_read     line read request, held until pmem_resp
//   pmem_write    line write request, held until pmem_resp
//   pmem_address  byte address (line aligned)
//   pmem_wdata    write line data
//   pmem_rdata    read line data, holds until the next read completes
//   pmem_resp     one-cycle completion pulse
//   proto_err     sticky protocol-error flag, cleared only by reset
//
// FSM states:
//   state | meaning
//   IDLE  | waiting for a request; a request seen here is accepted
//   BUSY  | latency countdown on the latched request
//   RESP  | pmem_resp high for this single cycle, then back to IDLE

module pmem_responder #(
  parameter int LINE_W     = 256,
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 4,
  parameter int INIT_ZERO  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [ADDR_W-1:0] pmem_address,
  input  logic [LINE_W-1:0] pmem_wdata,
  output logic [LINE_W-1:0] pmem_rdata,
  output logic              pmem_resp,
  output logic              proto_err
);

  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  // wide enough for LATENCY-1 plus the maximum jitter of 7
  localparam int CNT_W = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [LINE_W-1:0]       wdata_q, wdata_d;
  logic [LINE_W-1:0]       rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [LINE_W-1:0]       mem_q [DEPTH];

  logic                    req;
  logic [DEPTH_LOG2-1:0]   req_idx;
  logic                    req_off_err;
  logic                    done;
  logic                    commit;
  logic [CNT_W-1:0]        extra_lat;

  assign req         = pmem_read | pmem_write;
  assign req_idx     = pmem_address[OFF_W +: DEPTH_LOG2];
  assign req_off_err = |pmem_address[OFF_W-1:0];
  assign done        = (state_q == BUSY) && (cnt_q == '0);
  assign commit      = done && wr_q;

  // Upper address bits alias onto the same lines by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^pmem_address[ADDR_W-1:OFF_W+DEPTH_LOG2];

`ifdef PMEM_RESP_JITTER_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        lfsr_fb;

  // Fibonacci taps 16,14,13,11
  assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign lfsr_d    = {lfsr_q[14:0], lfsr_fb};
  assign extra_lat = CNT_W'(lfsr_q[2:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= 16'hACE1;
    else      lfsr_q <= lfsr_d;
  end
`else
  assign extra_lat = '0;
`endif

  // The counter holds the number of further BUSY edges before RESP, so
  // RESP is entered exactly LATENCY(+jitter) edges after acceptance; this
  // keeps LATENCY=1 on the same timing rule (one BUSY cycle at count 0).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          wr_d    = pmem_write;
          idx_d   = req_idx;
          wdata_d = pmem_wdata;
          cnt_d   = CNT_W'(LATENCY - 1) + extra_lat;
          state_d = BUSY;
          // both ops high resolves to a write
          if (req_off_err || (pmem_read && pmem_write)) err_d = 1'b1;
        end
      end
      BUSY: begin
        // the latched request completes even if the initiator lets go
        if (!req) err_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = RESP;
          if (!wr_q) rdata_d = mem_q[idx_q];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Write lands on the edge entering RESP; a reset before that edge
  // returns the FSM to IDLE so the pending write never commits.
  generate
    if (INIT_ZERO != 0) begin : g_mem_clr
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (commit) begin
          mem_q[idx_q] <= wdata_q;
        end
      end
    end else begin : g_mem_keep
      always_ff @(posedge clk) begin
        if (commit) mem_q[idx_q] <= wdata_q;
      end
    end
  endgenerate

  assign pmem_rdata = rdata_q;
  assign pmem_resp  = (state_q == RESP);
  assign proto_err  = err_q;

endmodule
